sum_serie_nibble: RTL and testbench

//  Multi-cycle adder for wide operands. Each cycle it feeds one 4-bit nibble of A and B,

---
 rtl/sum_serie_nibble_pkg.sv | 17 +
 rtl/sum_serie_nibble_sum4.sv | 30 +++
 rtl/sum_serie_nibble.sv | 100 ++++++++++
 tb/tb_sum_serie_nibble.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/sum_serie_nibble_pkg.sv
// rtl/sum_serie_nibble_pkg.sv - shared encodings for the nibble-serial adder
package sum_serie_nibble_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Index counter width: clog2(n), never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sum_serie_nibble_sum4.sv
// rtl/sum_serie_nibble_sum4.sv - 4-bit carry-lookahead adder slice
module sum4 (
  output logic [3:0] S,
  output logic       C_out,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       c_in
);

  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  assign p = A ^ B;
  assign g = A & B;

  // Every carry is a flat sum of products of generate/propagate terms.
  assign c[0] = c_in;
  assign c[1] = g[0] | (p[0] & c_in);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c_in);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c_in);

  assign S     = p ^ c[3:0];
  assign C_out = c[4];

endmodule

// File: rtl/sum_serie_nibble.sv
// rtl/sum_serie_nibble.sv - wide adder that walks one nibble per cycle through sum4
module sum_serie_nibble
  import sum_serie_nibble_pkg::*;
#(
  parameter int NIBBLES = 4,
  localparam int W = NIBBLE_W * NIBBLES
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  output logic [W-1:0] s,
  output logic         c_out,
  output logic         busy,
  output logic         done
);

  localparam int IDX_W = idx_width(NIBBLES);

  state_t             state;
  state_t             state_nxt;
  logic [W-1:0]       ra;
  logic [W-1:0]       rb;
  logic               cy;
  logic [IDX_W-1:0]   idx;
  logic               last;
  logic [NIBBLE_W-1:0] nib_a;
  logic [NIBBLE_W-1:0] nib_b;
  logic [NIBBLE_W-1:0] nib_s;
  logic               nib_c;

  assign last  = (idx == IDX_W'(NIBBLES - 1));
  assign nib_a = ra[idx*NIBBLE_W +: NIBBLE_W];
  assign nib_b = rb[idx*NIBBLE_W +: NIBBLE_W];

  sum4 u_sum4 (
    .S     (nib_s),
    .C_out (nib_c),
    .A     (nib_a),
    .B     (nib_b),
    .c_in  (cy)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Result is cleared on acceptance so stale upper nibbles never mix with a new sum.
  always_ff @(posedge clk) begin
    if (reset) begin
      ra    <= '0;
      rb    <= '0;
      cy    <= 1'b0;
      idx   <= '0;
      s     <= '0;
      c_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ra    <= a;
            rb    <= b;
            cy    <= c_in;
            idx   <= '0;
            s     <= '0;
            c_out <= 1'b0;
          end
        end
        RUN: begin
          s[idx*NIBBLE_W +: NIBBLE_W] <= nib_s;
          cy <= nib_c;
          if (last) begin
            c_out <= nib_c;
            idx   <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_sum_serie_nibble.sv
// tb/tb_sum_serie_nibble.sv - directed and random checks of the nibble-serial adder
`timescale 1ns/10ps
module tb_sum_serie_nibble;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        c_in;
  logic [15:0] s;
  logic        c_out;
  logic        busy;
  logic        done;

  logic        start1;
  logic [3:0]  a1;
  logic [3:0]  b1;
  logic        c_in1;
  logic [3:0]  s1;
  logic        c_out1;
  logic        busy1;
  logic        done1;

  int tests = 0;
  int fails = 0;
  logic [16:0] exp_q[$];
  logic [4:0]  exp_q1[$];

  always #5 clk = ~clk;

  sum_serie_nibble #(.NIBBLES(4)) u_dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .c_in(c_in),
    .s(s), .c_out(c_out), .busy(busy), .done(done)
  );

  sum_serie_nibble #(.NIBBLES(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .a(a1), .b(b1), .c_in(c_in1),
    .s(s1), .c_out(c_out1), .busy(busy1), .done(done1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Accept on one edge, then count edges until done; NIBBLES edges are expected.
  task automatic add4(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                      input string tag);
    int n;
    logic [16:0] e;
    @(negedge clk);
    a = ta; b = tb; c_in = tc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    exp_q.push_back({1'b0, ta} + {1'b0, tb} + {16'd0, tc});
    check({tag, " busy_after_accept"}, {31'd0, busy}, 32'd1);
    check({tag, " s_cleared"}, {15'd0, c_out, s}, 32'd0);
    n = 0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, " latency"}, n, 32'd4);
    e = exp_q.pop_front();
    check({tag, " result"}, {15'd0, c_out, s}, {15'd0, e});
    @(posedge clk); #1;
    check({tag, " done_pulse_len"}, {31'd0, done}, 32'd0);
    check({tag, " result_held"}, {15'd0, c_out, s}, {15'd0, e});
  endtask

  task automatic add1(input logic [3:0] ta, input logic [3:0] tb, input logic tc,
                      input string tag);
    int n;
    logic [4:0] e;
    @(negedge clk);
    a1 = ta; b1 = tb; c_in1 = tc; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    exp_q1.push_back({1'b0, ta} + {1'b0, tb} + {4'd0, tc});
    n = 0;
    while (!done1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, " latency1"}, n, 32'd1);
    e = exp_q1.pop_front();
    check({tag, " result1"}, {27'd0, c_out1, s1}, {27'd0, e});
    @(posedge clk); #1;
  endtask

  initial begin
    int pulses;
    logic [16:0] e;
    reset = 1'b1; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; c_in1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_s", {15'd0, c_out, s}, 32'd0);
    check("reset_flags", {30'd0, busy, done}, 32'd0);
    check("reset_flags1", {25'd0, busy1, done1, c_out1, s1}, 32'd0);
    @(negedge clk); reset = 1'b0;

    add4(16'h0000, 16'h0000, 1'b1, "t1");
    add4(16'hFFFF, 16'h0001, 1'b0, "t2");
    add4(16'hFFFF, 16'hFFFF, 1'b1, "t3a");
    add4(16'h0000, 16'hFFFF, 1'b1, "t3b");

    // Start pulses and operand changes during RUN must be ignored.
    @(negedge clk);
    a = 16'h5555; b = 16'hAAAA; c_in = 1'b0; start = 1'b1;
    exp_q.push_back(17'h0FFFF);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; c_in = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done) begin
        pulses++;
        e = exp_q.pop_front();
        check("t4 result", {15'd0, c_out, s}, {15'd0, e});
      end
    end
    check("t4 done_count", pulses, 32'd1);

    // Reset on the second RUN cycle aborts without a done pulse.
    @(negedge clk);
    a = 16'h1234; b = 16'h4321; c_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("t5 abort_state", {14'd0, busy, done, c_out, s}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check("t5 no_done", pulses, 32'd0);
    add4(16'h0FFF, 16'h0001, 1'b0, "t5b");

    // start held through the done cycle is taken only in the following IDLE cycle.
    @(negedge clk);
    a = 16'h0102; b = 16'h0304; c_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(posedge clk); #1;
    end
    check("t7 first", {15'd0, c_out, s}, 32'h0406);
    @(negedge clk);
    a = 16'h8000; b = 16'h8000; c_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    check("t7 idle_after_done", {30'd0, busy, done}, 32'd0);
    check("t7 result_kept", {15'd0, c_out, s}, 32'h0406);
    @(posedge clk); #1;
    start = 1'b0;
    check("t7 accepted", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 20 && !done; i++) begin
      @(posedge clk); #1;
    end
    check("t7 second", {15'd0, c_out, s}, 32'h10000);
    @(posedge clk); #1;

    add1(4'hF, 4'h1, 1'b1, "t6");
    for (int i = 0; i < 6; i++) begin
      add1(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           "rnd1");
    end
    for (int i = 0; i < 10; i++) begin
      add4(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), "rnd4");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
